sega_md_pad_emu: RTL and testbench

Responder end of the Sega Mega Drive 3/6-button pad protocol: presents a virtual MD pad on the DB9 user-port pins, driven by a 12-bit button word from the core. It watches the console-side SELECT line, tracks the 6-button phase sequence with an inactivity timeout, and drives the six active-low data pins. It sits between the joystick source (HPS or a DB15 reader) and the user-port output mux.

---
 rtl/sega_md_pad_emu_pkg.sv | 45 ++++
 rtl/sega_md_pad_emu_if.sv | 10 +
 rtl/sega_md_pad_emu_sync.sv | 22 ++
 rtl/sega_md_pad_emu.sv | 80 ++++++++
 tb/tb_sega_md_pad_emu.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sega_md_pad_emu_pkg.sv
// Shared definitions for the MD pad responder: button indices, phase encoding
// and the SELECT-phase to pin-row mapping.
package md_pad_pkg;

   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_B     = 4;
   localparam int BTN_C     = 5;
   localparam int BTN_A     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_Z     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_X     = 10;
   localparam int BTN_MODE  = 11;

   // H = SELECT high, L = SELECT low; numeric value is the phase index
   typedef enum logic [2:0] {
      PH_H0, PH_L0, PH_H1, PH_L1, PH_H2, PH_L2, PH_H3, PH_L3
   } md_phase_t;

   // sel picks the row group, row = phase[2:1] picks the row inside it, so a
   // phase whose parity disagrees with SELECT still yields a sane row.
   // Result bits: [0]Up [1]Down [2]Left [3]Right [4]TL [5]TR, active-low.
   function automatic logic [5:0] pin_row(input logic sel, input logic [1:0] row,
                                          input logic [11:0] btn);
      logic [11:0] p;
      p = ~btn;
      pin_row = 6'b111111;
      if (sel) begin
         if (row == 2'd3)
            pin_row = {p[BTN_C], p[BTN_B], p[BTN_MODE], p[BTN_X], p[BTN_Y], p[BTN_Z]};
         else
            pin_row = {p[BTN_C], p[BTN_B], p[BTN_RIGHT], p[BTN_LEFT], p[BTN_DOWN], p[BTN_UP]};
      end else begin
         case (row)
            2'd2:    pin_row = {p[BTN_START], p[BTN_A], 4'b0000};
            2'd3:    pin_row = {p[BTN_START], p[BTN_A], 4'b1111};
            default: pin_row = {p[BTN_START], p[BTN_A], 2'b00, p[BTN_DOWN], p[BTN_UP]};
         endcase
      end
   endfunction

endpackage

// File: rtl/sega_md_pad_emu_if.sv
// Pad-side signal bundle: SELECT and button word in, DB9 pin levels out.
interface sega_md_pad_emu_if;
   logic        select_in;
   logic [11:0] buttons;
   logic [5:0]  pad_out;
   logic        six_btn_id;

   modport master (output select_in, buttons, input pad_out, six_btn_id);
   modport slave  (input select_in, buttons, output pad_out, six_btn_id);
endinterface

// File: rtl/sega_md_pad_emu_sync.sv
// Two-flop synchronizer with selectable reset level, for user-port inputs.
module sync_2ff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_sys,
   input  logic         RESET,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/sega_md_pad_emu.sv
// Virtual Mega Drive pad on the DB9 user port. Define MD_PAD_SIX_BUTTON_EN for
// the 6-button phase sequencer; otherwise a plain 3-button pad is built.
module sega_md_pad_emu
   import md_pad_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TIMEOUT_US = 1500
) (
   input  logic               clk_sys,
   input  logic               RESET,
   sega_md_pad_emu_if.slave   pad
);
   localparam int TC = CLK_HZ / 1_000_000 * TIMEOUT_US;

   if (TC < 1) begin : g_bad_timeout
      $error("timeout must be at least one clk_sys cycle");
   end

   logic       sel_s;
   logic [5:0] pad_q;

   sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sel_sync (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .d       (pad.select_in),
      .q       (sel_s)
   );

   assign pad.pad_out = pad_q;

`ifdef MD_PAD_SIX_BUTTON_EN
   localparam int CW = $clog2(TC + 1);

   logic           sel_d, sel_edge, tmo;
   md_phase_t      phase, phase_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;

   always_comb begin
      sel_edge  = sel_s ^ sel_d;
      tmo       = (cnt == CW'(TC - 1));
      phase_nxt = phase;
      cnt_nxt   = cnt;
      if (sel_edge) begin
         phase_nxt = md_phase_t'(phase + 3'd1);
         cnt_nxt   = '0;
      end else if (tmo) begin
         phase_nxt = md_phase_t'({2'b00, ~sel_s});
         cnt_nxt   = '0;
      end else if (cnt != CW'(TC)) begin
         cnt_nxt   = cnt + 1'b1;
      end
   end

   // Output row follows phase_nxt so pins and phase land on the same edge and
   // SELECT-to-pin latency is the same in every phase.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         sel_d <= 1'b1;
         phase <= PH_H0;
         cnt   <= '0;
         pad_q <= 6'h3F;
      end else begin
         sel_d <= sel_s;
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         pad_q <= pin_row(sel_s, phase_nxt[2:1], pad.buttons);
      end
   end

   assign pad.six_btn_id = (phase == PH_L2);
`else
   always_ff @(posedge clk_sys) begin
      if (RESET) pad_q <= 6'h3F;
      else       pad_q <= pin_row(sel_s, 2'b00, pad.buttons);
   end

   assign pad.six_btn_id = 1'b0;
`endif

endmodule

// File: tb/tb_sega_md_pad_emu.sv
// Scoreboard bench for sega_md_pad_emu; expectations follow the pad protocol
// table and adapt to whether MD_PAD_SIX_BUTTON_EN is defined.
module tb_sega_md_pad_emu;
   localparam int CLK_HZ     = 1_000_000;
   localparam int TIMEOUT_US = 10;
   localparam int TC         = 10;

   logic clk_sys = 1'b0;
   logic RESET   = 1'b1;

   sega_md_pad_emu_if pad();

   sega_md_pad_emu #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
      .clk_sys (clk_sys),
      .RESET   (RESET),
      .pad     (pad)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      string      tag;
      logic [5:0] pins;
      logic       id;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          tb_ph = 0;
   logic        sel   = 1'b1;
   logic [11:0] btn   = 12'h010;

   function automatic logic [5:0] exp_pad(int ph, logic s, logic [11:0] b);
      logic up, dn, lf, rt, a, bb, c, st, x, y, z, md;
      {md, x, y, z, st, a, c, bb, up, dn, lf, rt} = ~b;
`ifndef MD_PAD_SIX_BUTTON_EN
      ph = s ? 0 : 1;
`endif
      case (ph)
         0, 2, 4: return {c, bb, rt, lf, dn, up};
         1, 3:    return {st, a, 1'b0, 1'b0, dn, up};
         5:       return {st, a, 4'b0000};
         6:       return {c, bb, md, x, y, z};
         default: return {st, a, 4'b1111};
      endcase
   endfunction

   function automatic logic exp_id(int ph);
`ifdef MD_PAD_SIX_BUTTON_EN
      return ph == 5;
`else
      return (ph < 0);
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic push(string tag, logic [5:0] p, logic id);
      exp_t e;
      e.tag = tag; e.pins = p; e.id = id;
      sbq.push_back(e);
   endtask

   task automatic pop_chk();
      exp_t e;
      if (sbq.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sbq.pop_front();
         chk({e.tag, "_pad"}, {26'd0, pad.pad_out}, {26'd0, e.pins});
         chk({e.tag, "_id"},  {31'd0, pad.six_btn_id}, {31'd0, e.id});
      end
   endtask

   task automatic set_btn(logic [11:0] b);
      btn = b;
      pad.buttons = b;
   endtask

   // Toggle SELECT; pins must still show the old row 2 cycles later and the
   // new row on the 3rd cycle.
   task automatic toggle(string tag, int post);
      int nph;
      nph = (tb_ph + 1) % 8;
      push({tag, "_old"}, exp_pad(tb_ph, sel, btn), exp_id(tb_ph));
      push({tag, "_new"}, exp_pad(nph, ~sel, btn), exp_id(nph));
      sel = ~sel;
      pad.select_in = sel;
      tick(2); pop_chk();
      tick(1); pop_chk();
      tb_ph = nph;
      tick(post);
   endtask

   // Called right after the edge that registered the last SELECT change.
   task automatic timeout_chk(string tag);
      int nph;
      nph = sel ? 0 : 1;
      push({tag, "_hold"}, exp_pad(tb_ph, sel, btn), exp_id(tb_ph));
      push({tag, "_fire"}, exp_pad(nph, sel, btn), exp_id(nph));
      tick(TC - 1); pop_chk();
      tick(1);      pop_chk();
      tb_ph = nph;
   endtask

   initial begin
      pad.select_in = 1'b1;
      pad.buttons   = btn;

      push("rst_hold", 6'h3F, 1'b0);
      tick(2); pop_chk();
      RESET = 1'b0;
      push("rst_b", exp_pad(0, 1'b1, btn), 1'b0);
      tick(1); pop_chk();

      set_btn(12'h0C0);
      toggle("sel_lo", 3);
      toggle("sel_hi", 0);
      timeout_chk("to_hi");

      set_btn(12'hF00);
      for (int i = 0; i < 7; i++) toggle("seq", (i == 6) ? 0 : 3);
      timeout_chk("to_p7");

      for (int i = 0; i < 5; i++) toggle("to6", (i == 4) ? 0 : 3);
      timeout_chk("to_p6");

      // Third SELECT change is registered in the same cycle the timer expires
      toggle("co_a", 3);
      toggle("co_b", 0);
      tick(7);
      toggle("co_edge", 3);
      toggle("co_c", 3);
      toggle("co_d", 3);

      while (tb_ph != 4) toggle("walk", 3);
      push("rst_mid", 6'h3F, 1'b0);
      RESET = 1'b1;
      tick(1); pop_chk();
      RESET = 1'b0;
      tb_ph = 0;
      push("rst_rel", exp_pad(0, sel, btn), 1'b0);
      tick(1); pop_chk();
      toggle("post_rst", 3);

      if (sbq.size() != 0) chk("sb_leftover", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
